uart_rx: RTL

UART_RX -- requirements
Module: uart_rx

---
 rtl/uart_rx.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchronized input, start-bit mid-point validation,
// one sample per bit period, single-cycle data_valid / framing_error pulses.
module uart_rx #(
    parameter int CLKS_PER_BIT = 5208
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       RxD,
    output logic [7:0] data,
    output logic       data_valid,
    output logic       framing_error,
    output logic       busy
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    localparam logic [15:0] HALF_M1 = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] FULL_M1 = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta_q;
    logic        rx_s_q;
    logic        rx_prev_q;

    logic [1:0]  state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic [2:0]  bit_idx_q, bit_idx_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  data_q, data_d;
    logic        dv_q, dv_d;
    logic        fe_q, fe_d;

    // Synchronizer and edge history idle high so a released reset never fakes a start edge
    // on a high line.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            rx_meta_q <= RxD;
            rx_s_q    <= rx_meta_q;
            rx_prev_q <= rx_s_q;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        data_d    = data_q;
        dv_d      = 1'b0;
        fe_d      = 1'b0;

        case (state_q)
            IDLE: begin
                // Only a true high-to-low transition starts a frame; a line stuck low is ignored.
                if (rx_prev_q && !rx_s_q) begin
                    state_d = START;
                    cnt_d   = 16'd0;
                end
            end

            START: begin
                if (cnt_q == HALF_M1) begin
                    cnt_d = 16'd0;
                    if (!rx_s_q) begin
                        state_d   = DATA;
                        bit_idx_d = 3'd0;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            DATA: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d              = 16'd0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d   = STOP;
                        bit_idx_d = 3'd0;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            STOP: begin
                if (cnt_q == FULL_M1) begin
                    cnt_d   = 16'd0;
                    state_d = IDLE;
                    if (rx_s_q) begin
                        data_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        fe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 16'd0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= 16'd0;
            bit_idx_q <= 3'd0;
            shift_q   <= 8'h00;
            data_q    <= 8'h00;
            dv_q      <= 1'b0;
            fe_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            dv_q      <= dv_d;
            fe_q      <= fe_d;
        end
    end

    assign data          = data_q;
    assign data_valid    = dv_q;
    assign framing_error = fe_q;
    assign busy          = (state_q != IDLE);

endmodule
